// File: rtl/mouse_position_tracker.sv
// mouse_position_tracker: assembles 3-byte PS/2 mouse packets and accumulates clamped cursor coordinates.
// Optional MOUSE_ACCEL_EN doubles any delta whose magnitude exceeds 8.
module mouse_position_tracker #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int INIT_X         = 320,
    parameter int INIT_Y         = 240,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [9:0] mouse_x,
    output logic [9:0] mouse_y,
    output logic [2:0] buttons,
    output logic       pos_update,
    output logic       sync_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {B0, B1, B2, APPLY} state_t;

    state_t            state, state_next;
    logic [6:0]        hdr;
    logic [7:0]        b1, b2;
    logic [CW-1:0]     cnt;
    logic              timeout, err_next;
    logic signed [11:0] dx_raw, dy_raw, dx, dy, nx, ny;
    logic [9:0]        cx, cy;

    assign timeout = (state == B1 || state == B2) && !rx_valid && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign err_next = (rx_valid && ((state == B0 && !rx_data[3]) || state == APPLY)) || timeout;

    always_comb begin
        state_next = state;
        case (state)
            B0:      state_next = (rx_valid && rx_data[3]) ? B1 : B0;
            B1:      state_next = rx_valid ? B2 : (timeout ? B0 : B1);
            B2:      state_next = rx_valid ? APPLY : (timeout ? B0 : B2);
            default: state_next = B0;
        endcase
    end

    // hdr = {y_ovf, x_ovf, y_sign, x_sign, buttons}; header bit 3 is always 1 and not kept
    assign dx_raw = hdr[5] ? 12'sd0 : {{4{hdr[3]}}, b1};
    assign dy_raw = hdr[6] ? 12'sd0 : {{4{hdr[4]}}, b2};
`ifdef MOUSE_ACCEL_EN
    assign dx = (dx_raw > 12'sd8 || dx_raw < -12'sd8) ? dx_raw <<< 1 : dx_raw;
    assign dy = (dy_raw > 12'sd8 || dy_raw < -12'sd8) ? dy_raw <<< 1 : dy_raw;
`else
    assign dx = dx_raw;
    assign dy = dy_raw;
`endif
    assign nx = $signed({2'b00, mouse_x}) + dx;
    assign ny = $signed({2'b00, mouse_y}) - dy;
    assign cx = nx < 12'sd0 ? 10'd0 : (nx > 12'(SCREEN_W - 1) ? 10'(SCREEN_W - 1) : nx[9:0]);
    assign cy = ny < 12'sd0 ? 10'd0 : (ny > 12'(SCREEN_H - 1) ? 10'(SCREEN_H - 1) : ny[9:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= B0;
            cnt        <= '0;
            mouse_x    <= 10'(INIT_X);
            mouse_y    <= 10'(INIT_Y);
            buttons    <= '0;
            pos_update <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= ((state == B1 || state == B2) && !rx_valid && !timeout) ? cnt + 1'b1 : '0;
            pos_update <= state == APPLY;
            sync_err   <= err_next;
            if (state == APPLY) begin
                mouse_x <= cx;
                mouse_y <= cy;
                buttons <= hdr[2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_valid && state == B0 && rx_data[3]) hdr <= {rx_data[7:4], rx_data[2:0]};
        if (rx_valid && state == B1) b1 <= rx_data;
        if (rx_valid && state == B2) b2 <= rx_data;
    end
endmodule
